// File: rtl/ps2_pkg.sv
// ps2_pkg: constants and types shared by the PS/2 key sequencer and its FIFO.
//   - prefix bytes (E0 extended, F0 break) and the list of bytes that are
//     never key codes (controller responses / errors) and reset the decoder
//   - decoder state enumeration; the encoding is {ext_seen, brk_seen}
//   - event record {code, ext, brk}
package ps2_pkg;

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  localparam int NUM_DISCARD = 7;
  localparam logic [7:0] DISCARD_LIST [NUM_DISCARD] =
    '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1};

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PFX_F0   = 2'b01,
    PFX_E0   = 2'b10,
    PFX_E0F0 = 2'b11
  } dec_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

  localparam int EVT_W = $bits(ps2_evt_t);

  function automatic logic is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_DISCARD; i++) begin
      if (b == DISCARD_LIST[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous event FIFO, power-of-two depth.
// Ports:
//   clk, rst_n    clock, async active-low reset (pointers/count only)
//   push, wdata   write request and data; ignored when full unless popping
//   pop           read request; ignored when empty
//   rdata         head entry, combinational; zero while empty
//   full, empty   status
//   count         occupancy 0..DEPTH
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // pointers are exactly AW bits, so wrap modulo DEPTH is free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: turns raw PS/2 scancode bytes into {code, ext, brk}
// key events queued in a FIFO.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   byte_in, byte_rdy   receiver byte and its ready level (async to clk)
//   evt_code/ext/break  head event fields (combinational from FIFO head)
//   evt_valid           FIFO non-empty
//   evt_pop             consumer takes the head event
//   evt_count           FIFO occupancy
//   ovf, ovf_clr        sticky overflow flag and its clear
// Optional build macro: PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes.
//
// state    | meaning
// IDLE     | no prefix pending
// PFX_E0   | E0 (extended) seen
// PFX_F0   | F0 (break) seen
// PFX_E0F0 | both E0 and F0 seen
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_rdy,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic                          evt_valid,
  input  logic                          evt_pop,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES);

  dec_state_t       state_q, state_d;
  logic             rdy_s1, rdy_s2, rdy_s3;
  logic             settled, armed;
  logic             accept;
  logic [TW-1:0]    tmo_cnt;
  logic             tmo_hit;
  logic             dec_push, push_d, push_q;
  ps2_evt_t         dec_evt, evt_q, head;
  logic [EVT_W-1:0] head_raw;
  logic             fifo_full, fifo_empty;

  // rdy_s3 is the edge-detect history. armed blocks a level that was
  // already high at reset release: it only sets once a post-reset sample
  // of rdy_s1 shows the line low (settled skips the reset value of rdy_s1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_s1  <= 1'b0;
      rdy_s2  <= 1'b0;
      rdy_s3  <= 1'b0;
      settled <= 1'b0;
      armed   <= 1'b0;
    end else begin
      rdy_s1  <= byte_rdy;
      rdy_s2  <= rdy_s1;
      rdy_s3  <= rdy_s2;
      settled <= 1'b1;
      if (settled && !rdy_s1) armed <= 1'b1;
    end
  end

  assign accept = armed && rdy_s2 && !rdy_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   tmo_cnt <= '0;
    else if (accept)              tmo_cnt <= '0;
    else if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state_q != IDLE) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dec_push = 1'b0;
    dec_evt  = '{code: byte_in, ext: 1'b0, brk: 1'b0};
    if (accept) begin
      if (is_discard(byte_in)) begin
        state_d = IDLE;
      end else if (byte_in == BYTE_EXT) begin
        case (state_q)
          IDLE, PFX_E0: state_d = PFX_E0;
          default:      state_d = PFX_E0F0;
        endcase
      end else if (byte_in == BYTE_BRK) begin
        case (state_q)
          IDLE, PFX_F0: state_d = PFX_F0;
          default:      state_d = PFX_E0F0;
        endcase
      end else begin
        dec_push    = 1'b1;
        dec_evt.ext = (state_q == PFX_E0) || (state_q == PFX_E0F0);
        dec_evt.brk = (state_q == PFX_F0) || (state_q == PFX_E0F0);
        state_d     = IDLE;
      end
    end else if (tmo_hit) begin
      state_d = IDLE;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       rec_valid;
  logic [7:0] rec_code;
  logic       rec_ext;
  logic       rec_hit;

  assign rec_hit = rec_valid && (rec_code == dec_evt.code) && (rec_ext == dec_evt.ext);
  assign push_d  = dec_push && !(rec_hit && !dec_evt.brk);

  // remembers the last make; its own break forgets it so the next press counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_valid <= 1'b0;
      rec_code  <= '0;
      rec_ext   <= 1'b0;
    end else if (dec_push) begin
      if (!dec_evt.brk) begin
        rec_valid <= 1'b1;
        rec_code  <= dec_evt.code;
        rec_ext   <= dec_evt.ext;
      end else if (rec_hit) begin
        rec_valid <= 1'b0;
      end
    end
  end
`else
  assign push_d = dec_push;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q <= 1'b0;
      evt_q  <= '0;
      ovf    <= 1'b0;
    end else begin
      push_q <= push_d;
      if (push_d) evt_q <= dec_evt;
      // set has priority over clear
      if (push_q && fifo_full && !evt_pop) ovf <= 1'b1;
      else if (ovf_clr)                    ovf <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (evt_pop),
    .wdata (evt_q),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (evt_count)
  );

  assign head      = head_raw;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;
  assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer: scenario bench for ps2_key_sequencer. Expected events
// are queued as bytes are driven and compared as the DUT presents them.
// Honors PS2_TYPEMATIC_FILTER_EN to match the DUT build.
module tb_ps2_key_sequencer;
  import ps2_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [7:0]               byte_in;
  logic                     byte_rdy;
  logic [7:0]               evt_code;
  logic                     evt_ext;
  logic                     evt_break;
  logic                     evt_valid;
  logic                     evt_pop;
  logic [$clog2(DEPTH):0]   evt_count;
  logic                     ovf;
  logic                     ovf_clr;

  int n_checks = 0;
  int n_pass   = 0;
  ps2_evt_t exp_q[$];

  always #5 clk = ~clk;

  ps2_key_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (byte_in),
    .byte_rdy  (byte_rdy),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .evt_valid (evt_valid),
    .evt_pop   (evt_pop),
    .evt_count (evt_count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  function automatic ps2_evt_t mk(input logic [7:0] c, input logic e, input logic b);
    ps2_evt_t r;
    r.code = c;
    r.ext  = e;
    r.brk  = b;
    return r;
  endfunction

  function automatic ps2_evt_t head_now();
    ps2_evt_t r;
    r.code = evt_code;
    r.ext  = evt_ext;
    r.brk  = evt_break;
    return r;
  endfunction

  // one byte: rises on a falling clk edge, held 6 cycles, low 4 cycles
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_in  = b;
    byte_rdy = 1'b1;
    repeat (6) @(negedge clk);
    byte_rdy = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // scoreboard consumer: pop and compare until the expected queue is empty
  task automatic drain(input string name);
    ps2_evt_t obs;
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 60) begin
      if (evt_valid === 1'b1) begin
        obs = head_now();
        n_checks++;
        if (obs !== exp_q[0])
          $display("FAIL %s event: got code=%h ext=%b brk=%b, want code=%h ext=%b brk=%b",
                   name, obs.code, obs.ext, obs.brk, exp_q[0].code, exp_q[0].ext, exp_q[0].brk);
        else n_pass++;
        void'(exp_q.pop_front());
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0 || evt_valid !== 1'b0) begin
      $display("FAIL %s drain: missing=%0d evt_valid=%b, want missing=0 evt_valid=0",
               name, exp_q.size(), evt_valid);
      exp_q.delete();
      evt_pop = 1'b1;
      repeat (DEPTH) @(negedge clk);
      evt_pop = 1'b0;
    end else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({evt_valid, evt_count} !== '0)
      $display("FAIL reset_fifo: got valid=%b count=%0d, want 0/0", evt_valid, evt_count);
    else n_pass++;
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b, want 0", ovf);
    else n_pass++;
    n_checks++;
    if ({evt_code, evt_ext, evt_break} !== 10'h000)
      $display("FAIL reset_head: got %h/%b/%b, want 00/0/0", evt_code, evt_ext, evt_break);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency();
    int k;
    exp_q.push_back(mk(8'h1C, 1'b0, 1'b0));
    @(negedge clk);
    byte_in  = 8'h1C;
    byte_rdy = 1'b1;
    k = 0;
    while (evt_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (!(k >= 3 && k <= 4)) $display("FAIL latency: got %0d clk, want 3..4", k);
    else n_pass++;
    repeat (3) @(negedge clk);
    byte_rdy = 1'b0;
    repeat (4) @(negedge clk);
    drain("make_1c");
  endtask

  task automatic test_prefix();
    send_byte(8'hE0);
    send_byte(8'hF0);
    n_checks++;
    if (evt_count !== '0) $display("FAIL prefix_silent: got count=%0d, want 0", evt_count);
    else n_pass++;
    send_byte(8'h75);
    exp_q.push_back(mk(8'h75, 1'b1, 1'b1));
    drain("e0_f0_75");

    send_byte(8'hE0); send_byte(8'h74);                  exp_q.push_back(mk(8'h74, 1'b1, 1'b0));
    send_byte(8'hF0); send_byte(8'h74);                  exp_q.push_back(mk(8'h74, 1'b0, 1'b1));
    send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h70); exp_q.push_back(mk(8'h70, 1'b1, 1'b0));
    drain("ext_brk_set1");
    send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h71); exp_q.push_back(mk(8'h71, 1'b0, 1'b1));
    send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h72); exp_q.push_back(mk(8'h72, 1'b1, 1'b1));
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h73);
    exp_q.push_back(mk(8'h73, 1'b1, 1'b1));
    drain("ext_brk_set2");
    send_byte(8'hE0); send_byte(8'hAA); send_byte(8'h1C); exp_q.push_back(mk(8'h1C, 1'b0, 1'b0));
    send_byte(8'hF0); send_byte(8'h00); send_byte(8'h2A); exp_q.push_back(mk(8'h2A, 1'b0, 1'b0));
    send_byte(8'hFA);
    drain("discard");
  endtask

  task automatic test_timeout();
    send_byte(8'hF0);
    send_byte(8'h1B);
    exp_q.push_back(mk(8'h1B, 1'b0, 1'b1));
    drain("break_in_time");
    send_byte(8'hF0);
    repeat (TMO + 10) @(negedge clk);
    send_byte(8'h1C);
    exp_q.push_back(mk(8'h1C, 1'b0, 1'b0));
    drain("break_timeout");
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) begin
      send_byte(8'(8'h10 + i));
      if (i < DEPTH) exp_q.push_back(mk(8'(8'h10 + i), 1'b0, 1'b0));
    end
    n_checks++;
    if (evt_count !== (DEPTH + 1)'(DEPTH))
      $display("FAIL ovf_count: got %0d, want %0d", evt_count, DEPTH);
    else n_pass++;
    n_checks++;
    if (ovf !== 1'b1) $display("FAIL ovf_set: got %b, want 1", ovf);
    else n_pass++;
    n_checks++;
    if (evt_code !== 8'h10) $display("FAIL ovf_head: got %h, want 10", evt_code);
    else n_pass++;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL ovf_clr: got %b, want 0", ovf);
    else n_pass++;
    drain("ovf_contents");
  endtask

  task automatic test_back_to_back();
    ps2_evt_t obs;
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(8'h21 + i));
      exp_q.push_back(mk(8'(8'h21 + i), 1'b0, 1'b0));
    end
    // push lands on the 4th rising edge after byte_rdy rises; pop on that same edge
    @(negedge clk);
    byte_in  = 8'h25;
    byte_rdy = 1'b1;
    repeat (3) @(negedge clk);
    obs = head_now();
    n_checks++;
    if (obs !== exp_q[0]) $display("FAIL b2b_head: got %h, want %h", obs.code, exp_q[0].code);
    else n_pass++;
    void'(exp_q.pop_front());
    evt_pop = 1'b1;
    @(negedge clk);
    evt_pop = 1'b0;
    exp_q.push_back(mk(8'h25, 1'b0, 1'b0));
    n_checks++;
    if (evt_count !== (DEPTH + 1)'(DEPTH) || ovf !== 1'b0)
      $display("FAIL b2b_full: got count=%0d ovf=%b, want %0d/0", evt_count, ovf, DEPTH);
    else n_pass++;
    repeat (2) @(negedge clk);
    byte_rdy = 1'b0;
    repeat (4) @(negedge clk);
    drain("b2b_order");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h10);
    send_byte(8'h11);
    send_byte(8'hE0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (evt_valid !== 1'b0 || evt_count !== '0)
      $display("FAIL reset_mid: got valid=%b count=%0d, want 0/0", evt_valid, evt_count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h75);
    exp_q.push_back(mk(8'h75, 1'b0, 1'b0));
    drain("after_reset_mid");

    @(negedge clk);
    byte_in  = 8'h33;
    byte_rdy = 1'b1;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (evt_count !== '0) $display("FAIL rdy_high_at_reset: got count=%0d, want 0", evt_count);
    else n_pass++;
    byte_rdy = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h34);
    exp_q.push_back(mk(8'h34, 1'b0, 1'b0));
    drain("after_rdy_high");
  endtask

  task automatic test_typematic();
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_q.push_back(mk(8'h1C, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h1C, 1'b0, 1'b1));
`else
    exp_q.push_back(mk(8'h1C, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h1C, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h1C, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h1C, 1'b0, 1'b1));
`endif
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    drain("typematic");
  endtask

  initial begin
    rst_n    = 1'b0;
    byte_in  = 8'h00;
    byte_rdy = 1'b0;
    evt_pop  = 1'b0;
    ovf_clr  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_latency();
    test_prefix();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_typematic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, idle clk cycles after which a partial prefix sequence is abandoned.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 byte_in  input  8  scancode byte from the PS/2 receiver; stable while byte_rdy high.
REQ-006 byte_rdy  input  1  receiver byte-ready level; asynchronous to clk.
REQ-007 evt_code  output  8  key code of FIFO head event.
REQ-008 evt_ext  output  1  head event carried E0 prefix.
REQ-009 evt_break  output  1  head event is a release (F0 prefix).
REQ-010 evt_valid  output  1  FIFO non-empty.
REQ-011 evt_pop  input  1  consumer accepts head when evt_valid high.
REQ-012 evt_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 ovf_clr  input  1  clears ovf.

Function
REQ-015 byte_rdy SHALL pass a 2-flop synchronizer; a byte is accepted on the cycle the synchronized level rises (0->1); byte_in is sampled that cycle, latency 3 clk from byte_rdy rise.
REQ-016 Decoder FSM states SHALL be IDLE, PFX_E0, PFX_F0, PFX_E0F0.
REQ-017 IDLE: 0xE0->PFX_E0; 0xF0->PFX_F0; other code->push {code,ext=0,brk=0}, stay IDLE.
REQ-018 PFX_E0: 0xF0->PFX_E0F0; 0xE0->stay; other->push {code,1,0}, ->IDLE.
REQ-019 PFX_F0: 0xE0->PFX_E0F0; 0xF0->stay; other->push {code,0,1}, ->IDLE.
REQ-020 PFX_E0F0: 0xE0/0xF0->stay; other->push {code,1,1}, ->IDLE.
REQ-021 Bytes 0x00, 0xFF, 0xAA, 0xFA, 0xFE, 0xEE, 0xE1 SHALL be discarded in any state and force IDLE; no push.
REQ-022 Timeout counter SHALL reset on every accepted byte; in any non-IDLE state reaching TIMEOUT_CYCLES consecutive cycles without a byte SHALL force IDLE with no push; counter saturates in IDLE.
REQ-023 Push SHALL complete the cycle after acceptance; event visible at head (evt_valid) one cycle after push when FIFO was empty.
REQ-024 evt_pop with evt_valid low SHALL be ignored; evt_code/ext/break SHALL be combinational from head entry.
REQ-025 Push when full and no pop in same cycle: event dropped, ovf set to 1; FIFO unchanged.
REQ-026 Push and pop in same cycle (full or not): both take effect, evt_count unchanged.
REQ-027 ovf_clr and new overflow in same cycle: ovf SHALL stay 1 (set wins).
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 rst_n low SHALL immediately force: FSM IDLE, FIFO empty, evt_valid=0, evt_count=0, ovf=0, evt_code=0, evt_ext=0, evt_break=0, synchronizer flops 0, timeout counter 0.
REQ-030 A byte_rdy already high at reset release SHALL NOT be accepted until it falls and rises again.
REQ-031 Reset mid-sequence SHALL discard the partial prefix and all queued events.

Configuration
REQ-032 Macro PS2_TYPEMATIC_FILTER_EN: when defined, a make event whose {code,ext} equals the last pushed make with no intervening break of that key SHALL be dropped (auto-repeat suppressed); a break of that key clears the record; record clears on reset.
REQ-033 Without PS2_TYPEMATIC_FILTER_EN every repeated make SHALL be pushed.

Structure
REQ-034 Shared package ps2_pkg SHALL hold the prefix/special byte constants (0xE0, 0xF0, discard list), the FSM state enumeration and the event record type {code[7:0], ext, brk}.
REQ-035 FIFO SHALL be a separate sub-module ps2_evt_fifo (width 10, depth FIFO_DEPTH, push/pop/full/empty/count); decoder, synchronizer, timeout and filter stay in ps2_key_sequencer.

Verification
REQ-036 Bytes 0x1C -> one event {0x1C,0,0}, evt_valid 3-4 clk after byte_rdy rise.
REQ-037 Bytes 0xE0,0xF0,0x75 -> single event {0x75,1,1}; no events for prefix bytes.
REQ-038 0xF0 then idle TIMEOUT_CYCLES+1, then 0x1C -> event {0x1C,0,0} (break prefix abandoned).
REQ-039 FIFO_DEPTH+1 makes, no pop -> evt_count=FIFO_DEPTH, ovf=1, head=first code; ovf_clr -> ovf=0.
REQ-040 Full FIFO, push and pop same cycle -> count stays FIFO_DEPTH, ovf stays 0, newest entry at tail.
REQ-041 With PS2_TYPEMATIC_FILTER_EN: 0x1C,0x1C,0x1C,0xF0,0x1C -> events {0x1C,0,0},{0x1C,0,1} only; without macro -> four events.
